// File: rtl/ph_reg3_drain.sv
// Host-side drain engine for the register 3 FIFO: reads bytes with single-cycle strobes
// in one- or two-byte bursts and forwards them through a small ready/valid buffer.
module ph_reg3_drain #(
    parameter int unsigned BUF_DEPTH = 4,
    parameter int unsigned COUNT_W   = 16
) (
    input  logic               h_phi2,
    input  logic               h_rst,
    input  logic               start,
    input  logic               abort,
    input  logic               one_byte_mode,
    input  logic [COUNT_W-1:0] count,
    input  logic [7:0]         fifo_h_data,
    input  logic               fifo_h_data_available,
    output logic               fifo_h_select,
    output logic               fifo_h_rd,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [COUNT_W-1:0] remaining
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StRead0,
        StRead1,
        StGap,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] remaining_q, remaining_d;
    logic               mode_q, mode_d;
    logic               abort_pend_q, abort_pend_d;
    logic               zero_done_q, zero_done_d;
    logic               err_q, err_d;

    logic [7:0]         buf_mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   buf_cnt_q, buf_cnt_d;

    logic               strobe;
    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   free_space;
    logic [CNT_W-1:0]   burst_sz;

    assign strobe     = (state_q == StRead0) || (state_q == StRead1);
    assign push       = strobe;
    assign pop        = out_valid && out_ready;
    assign free_space = CNT_W'(BUF_DEPTH) - buf_cnt_q;
    assign burst_sz   = mode_q ? CNT_W'(1) : CNT_W'(2);

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        mode_d       = mode_q;
        abort_pend_d = abort_pend_q;
        zero_done_d  = 1'b0;
        err_d        = 1'b0;

        unique case (state_q)
            StIdle: begin
                abort_pend_d = 1'b0;
                if (start) begin
                    if (count == '0) begin
                        zero_done_d = 1'b1;
                    end else if (!one_byte_mode && count[0]) begin
                        // An odd count in pair mode would leave a half-drained pair.
                        err_d = 1'b1;
                    end else begin
                        remaining_d = count;
                        mode_d      = one_byte_mode;
                        state_d     = StWait;
                    end
                end
            end
            StWait: begin
                if (abort) begin
                    state_d = StDone;
                end else if (fifo_h_data_available && (free_space >= burst_sz)) begin
                    state_d = StRead0;
                end
            end
            StRead0: begin
                remaining_d = remaining_q - COUNT_W'(1);
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                state_d = mode_q ? StGap : StRead1;
            end
            StRead1: begin
                remaining_d = remaining_q - COUNT_W'(1);
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                state_d = StGap;
            end
            StGap: begin
                if ((remaining_q == '0) || abort_pend_q || abort) begin
                    state_d = StDone;
                end else begin
                    state_d = StWait;
                end
            end
            StDone: begin
                abort_pend_d = 1'b0;
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        buf_cnt_d = buf_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   buf_cnt_d = buf_cnt_q + CNT_W'(1);
            2'b01:   buf_cnt_d = buf_cnt_q - CNT_W'(1);
            default: buf_cnt_d = buf_cnt_q;
        endcase
    end

    always_ff @(posedge h_phi2) begin
        if (h_rst) begin
            state_q      <= StIdle;
            remaining_q  <= '0;
            mode_q       <= 1'b0;
            abort_pend_q <= 1'b0;
            zero_done_q  <= 1'b0;
            err_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            buf_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            mode_q       <= mode_d;
            abort_pend_q <= abort_pend_d;
            zero_done_q  <= zero_done_d;
            err_q        <= err_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            buf_cnt_q    <= buf_cnt_d;
        end
    end

    // Storage needs no reset; out_data is masked while the buffer is empty.
    always_ff @(posedge h_phi2) begin
        if (push) begin
            buf_mem_q[wr_ptr_q] <= fifo_h_data;
        end
    end

    assign fifo_h_select = strobe;
    assign fifo_h_rd     = strobe;
    assign out_valid     = (buf_cnt_q != '0);
    assign out_data      = out_valid ? buf_mem_q[rd_ptr_q] : 8'h00;
    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StDone) || zero_done_q;
    assign err           = err_q;
    assign remaining     = remaining_q;

endmodule

// File: tb/tb_ph_reg3_drain.sv
// Directed bench for ph_reg3_drain: behavioural FIFO source and stream sink around the DUT.
module tb_ph_reg3_drain;

    logic        h_phi2 = 1'b0;
    logic        h_rst;
    logic        start;
    logic        abort;
    logic        one_byte_mode;
    logic [15:0] count;
    logic [7:0]  fifo_h_data;
    logic        fifo_h_data_available;
    logic        fifo_h_select;
    logic        fifo_h_rd;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] remaining;

    int checks = 0;
    int errors = 0;

    logic [7:0] fifo_mem [256];
    logic [7:0] fifo_idx = 8'd0;
    logic [7:0] rx_mem [256];
    int         rx_cnt = 0;

    ph_reg3_drain #(
        .BUF_DEPTH (4),
        .COUNT_W   (16)
    ) dut (
        .h_phi2                (h_phi2),
        .h_rst                 (h_rst),
        .start                 (start),
        .abort                 (abort),
        .one_byte_mode         (one_byte_mode),
        .count                 (count),
        .fifo_h_data           (fifo_h_data),
        .fifo_h_data_available (fifo_h_data_available),
        .fifo_h_select         (fifo_h_select),
        .fifo_h_rd             (fifo_h_rd),
        .out_data              (out_data),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .busy                  (busy),
        .done                  (done),
        .err                   (err),
        .remaining             (remaining)
    );

    always #5 h_phi2 = ~h_phi2;

    assign fifo_h_data = fifo_mem[fifo_idx];

    always @(posedge h_phi2) begin
        if (fifo_h_rd === 1'b1) begin
            fifo_idx <= fifo_idx + 8'd1;
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            rx_mem[rx_cnt[7:0]] <= out_data;
            rx_cnt <= rx_cnt + 1;
        end
    end

    task automatic step();
        @(posedge h_phi2);
        #1;
    endtask

    task automatic test_reset();
        h_rst = 1'b1;
        step();
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (fifo_h_rd !== 1'b0 || fifo_h_select !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b/%b want 0/0", fifo_h_rd, fifo_h_select); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_done_err got %b/%b want 0/0", done, err); end
        checks++; if (remaining !== 16'd0) begin errors++; $display("FAIL reset_remaining got %0d want 0", remaining); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
        h_rst = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got %b want 0", busy); end
    endtask

    task automatic test_one_byte();
        logic [15:0] smask;
        logic [15:0] dmask;
        logic [7:0]  exp_b [3];
        int          base;
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
        for (int k = 0; k < 3; k++) fifo_mem[fifo_idx + 8'(k)] = exp_b[k];
        base = rx_cnt;
        one_byte_mode = 1'b1; count = 16'd3; fifo_h_data_available = 1'b1; out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        smask = '0; dmask = '0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL one_byte_busy got %b want 1", busy); end
        for (int c = 2; c <= 14; c++) begin
            step();
            smask[c] = fifo_h_rd;
            dmask[c] = done;
            if (c == 2) begin
                checks++; if (remaining !== 16'd3) begin errors++; $display("FAIL one_byte_rem_start got %0d want 3", remaining); end
            end
            if (c == 3) begin
                checks++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin errors++; $display("FAIL one_byte_latency got %b/%h want 1/11", out_valid, out_data); end
            end
        end
        checks++; if (smask !== 16'h0124) begin errors++; $display("FAIL one_byte_strobes got %h want 0124", smask); end
        checks++; if (dmask !== 16'h0400) begin errors++; $display("FAIL one_byte_done got %h want 0400", dmask); end
        checks++; if (remaining !== 16'd0 || busy !== 1'b0) begin errors++; $display("FAIL one_byte_end got rem %0d busy %b want 0 0", remaining, busy); end
        checks++; if (rx_cnt - base != 3) begin errors++; $display("FAIL one_byte_rx_count got %0d want 3", rx_cnt - base); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (rx_mem[8'(base + k)] !== exp_b[k]) begin errors++; $display("FAIL one_byte_data[%0d] got %h want %h", k, rx_mem[8'(base + k)], exp_b[k]); end
        end
    endtask

    task automatic test_two_byte();
        logic [15:0] smask;
        logic [15:0] dmask;
        logic [7:0]  exp_b [4];
        int          base;
        exp_b[0] = 8'hA1; exp_b[1] = 8'hA2; exp_b[2] = 8'hA3; exp_b[3] = 8'hA4;
        for (int k = 0; k < 4; k++) fifo_mem[fifo_idx + 8'(k)] = exp_b[k];
        base = rx_cnt;
        one_byte_mode = 1'b0; count = 16'd4; fifo_h_data_available = 1'b1; out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        smask = '0; dmask = '0;
        for (int c = 2; c <= 12; c++) begin
            step();
            smask[c] = fifo_h_rd;
            dmask[c] = done;
        end
        checks++; if (smask !== 16'h00CC) begin errors++; $display("FAIL two_byte_strobes got %h want 00cc", smask); end
        checks++; if (dmask !== 16'h0200) begin errors++; $display("FAIL two_byte_done got %h want 0200", dmask); end
        checks++; if (rx_cnt - base != 4) begin errors++; $display("FAIL two_byte_rx_count got %0d want 4", rx_cnt - base); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (rx_mem[8'(base + k)] !== exp_b[k]) begin errors++; $display("FAIL two_byte_data[%0d] got %h want %h", k, rx_mem[8'(base + k)], exp_b[k]); end
        end
    endtask

    task automatic test_reject();
        logic [7:0] idx0;
        idx0 = fifo_idx;
        fifo_h_data_available = 1'b1;
        one_byte_mode = 1'b0; count = 16'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL odd_count_err got err %b busy %b want 1 0", err, busy); end
        step();
        checks++; if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL odd_count_pulse got err %b busy %b want 0 0", err, busy); end
        one_byte_mode = 1'b1; count = 16'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_one_done got done %b busy %b want 1 0", done, busy); end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_one_pulse got %b want 0", done); end
        one_byte_mode = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_two_done got done %b err %b busy %b want 1 0 0", done, err, busy); end
        step();
        step();
        checks++; if (fifo_idx !== idx0) begin errors++; $display("FAIL reject_no_strobe got %0d reads want 0", fifo_idx - idx0); end
    endtask

    task automatic test_backpressure();
        logic [7:0] idx0;
        int         base;
        logic       seen_done;
        idx0 = fifo_idx;
        for (int k = 0; k < 8; k++) fifo_mem[fifo_idx + 8'(k)] = 8'h40 + 8'(k);
        base = rx_cnt;
        one_byte_mode = 1'b0; count = 16'd8; fifo_h_data_available = 1'b1; out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (20) step();
        checks++; if (fifo_idx - idx0 !== 8'd4) begin errors++; $display("FAIL bp_stall_reads got %0d want 4", fifo_idx - idx0); end
        checks++; if (busy !== 1'b1 || remaining !== 16'd4 || fifo_h_rd !== 1'b0) begin errors++; $display("FAIL bp_stall_state got busy %b rem %0d rd %b want 1 4 0", busy, remaining, fifo_h_rd); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h40) begin errors++; $display("FAIL bp_head got %b/%h want 1/40", out_valid, out_data); end
        out_ready = 1'b1;
        seen_done = 1'b0;
        for (int c = 0; c < 60 && !seen_done; c++) begin
            step();
            if (done === 1'b1) seen_done = 1'b1;
        end
        checks++; if (seen_done !== 1'b1) begin errors++; $display("FAIL bp_done_timeout got 0 want 1"); end
        repeat (4) step();
        checks++; if (fifo_idx - idx0 !== 8'd8) begin errors++; $display("FAIL bp_total_reads got %0d want 8", fifo_idx - idx0); end
        checks++; if (rx_cnt - base != 8) begin errors++; $display("FAIL bp_rx_count got %0d want 8", rx_cnt - base); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (rx_mem[8'(base + k)] !== 8'h40 + 8'(k)) begin errors++; $display("FAIL bp_data[%0d] got %h want %h", k, rx_mem[8'(base + k)], 8'h40 + 8'(k)); end
        end
    endtask

    task automatic test_abort_read0();
        logic [7:0] idx0;
        int         base;
        idx0 = fifo_idx;
        fifo_mem[fifo_idx] = 8'h5A;
        fifo_mem[fifo_idx + 8'd1] = 8'h5B;
        base = rx_cnt;
        one_byte_mode = 1'b0; count = 16'd8; fifo_h_data_available = 1'b1; out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++; if (fifo_h_rd !== 1'b1) begin errors++; $display("FAIL abort_r0_strobe got %b want 1", fifo_h_rd); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if (fifo_h_rd !== 1'b1) begin errors++; $display("FAIL abort_r1_strobe got %b want 1", fifo_h_rd); end
        step();
        checks++; if (fifo_h_rd !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_gap got rd %b done %b want 0 0", fifo_h_rd, done); end
        step();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_done got %b want 1", done); end
        step();
        checks++; if (busy !== 1'b0 || remaining !== 16'd6) begin errors++; $display("FAIL abort_end got busy %b rem %0d want 0 6", busy, remaining); end
        out_ready = 1'b1;
        repeat (4) step();
        checks++; if (fifo_idx - idx0 !== 8'd2) begin errors++; $display("FAIL abort_reads got %0d want 2", fifo_idx - idx0); end
        checks++; if (rx_cnt - base != 2) begin errors++; $display("FAIL abort_rx_count got %0d want 2", rx_cnt - base); end
        checks++; if (rx_mem[8'(base)] !== 8'h5A || rx_mem[8'(base + 1)] !== 8'h5B) begin errors++; $display("FAIL abort_data got %h %h want 5a 5b", rx_mem[8'(base)], rx_mem[8'(base + 1)]); end
    endtask

    task automatic test_abort_wait();
        logic [7:0] idx0;
        idx0 = fifo_idx;
        fifo_h_data_available = 1'b0;
        one_byte_mode = 1'b1; count = 16'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL abort_wait_busy got busy %b done %b want 1 0", busy, done); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_wait_done got %b want 1", done); end
        step();
        checks++; if (busy !== 1'b0 || done !== 1'b0 || fifo_idx !== idx0) begin errors++; $display("FAIL abort_wait_end got busy %b done %b reads %0d want 0 0 0", busy, done, fifo_idx - idx0); end
    endtask

    task automatic test_reset_mid();
        fifo_mem[fifo_idx] = 8'h71;
        fifo_mem[fifo_idx + 8'd1] = 8'h72;
        one_byte_mode = 1'b0; count = 16'd8; fifo_h_data_available = 1'b1; out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        checks++; if (out_valid !== 1'b1 || remaining !== 16'd6 || busy !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got valid %b rem %0d busy %b want 1 6 1", out_valid, remaining, busy); end
        h_rst = 1'b1;
        step();
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_state got busy %b valid %b want 0 0", busy, out_valid); end
        checks++; if (remaining !== 16'd0 || fifo_h_rd !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL rst_mid_outs got rem %0d rd %b data %h want 0 0 00", remaining, fifo_h_rd, out_data); end
        h_rst = 1'b0;
        fifo_h_data_available = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_after got busy %b valid %b want 0 0", busy, out_valid); end
    endtask

    initial begin
        h_rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        one_byte_mode = 1'b0;
        count = 16'd0;
        fifo_h_data_available = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_one_byte();
        test_two_byte();
        test_reject();
        test_backpressure();
        test_abort_read0();
        test_abort_wait();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/ph_reg3_drain.md
# ph_reg3_drain

Host-side drain engine for the parasite-to-host register 3 FIFO. Once programmed with a byte count, it waits for the FIFO's host data-available flag. It then issues single-cycle host read strobes, one or two per burst depending on the latched mode, and forwards each byte into a ready/valid stream through a small internal buffer. It is the direct downstream consumer of the register 3 host port and replaces CPU-driven polling during block transfers.

## Interface
- BUF_DEPTH, 4: output buffer entries; power of two, minimum 2.
- COUNT_W, 16: width of the transfer byte count.

Clock and reset:
- h_phi2  in  1  host clock. One clock; every register in the block is clocked on the rising edge.
- h_rst  in  1  reset, synchronous and active-high.

Control:
- start  in  1  single-cycle request to begin a transfer; ignored unless idle.
- abort  in  1  stop the transfer at the next burst boundary.
- one_byte_mode  in  1  FIFO mode; latched at start.
- count  in  COUNT_W  bytes to transfer; latched at start.

FIFO side:
- fifo_h_data  in  8  FIFO host data output.
- fifo_h_data_available  in  1  FIFO host data-available flag.
- fifo_h_select  out  1  data register select.
- fifo_h_rd  out  1  read strobe; always equal to fifo_h_select.

Stream side:
- out_data  out  8  head byte of the output buffer.
- out_valid  out  1  output buffer not empty.
- out_ready  in  1  downstream accepts out_data.

Status:
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a transfer completes or is aborted.
- err  out  1  one-cycle pulse when a start is rejected.
- remaining  out  COUNT_W  bytes still to be read from the FIFO.

## Operation
- State machine states: IDLE, WAIT, READ0, READ1, GAP, DONE. All outputs are registered or decoded from state (Moore).
- IDLE, on start:
  - count == 0: pulse done next cycle; stay IDLE.
  - Two-byte mode (one_byte_mode = 0) with odd count: pulse err; stay IDLE. A half-drained pair is never allowed.
  - Otherwise: latch count into remaining and latch the mode; go to WAIT.
- WAIT:
  - abort: go to DONE.
  - fifo_h_data_available = 1 and buffer free space ≥ burst size: go to READ0. Burst size is 1 in one-byte mode and 2 in two-byte mode.
- READ0:
  - fifo_h_select and fifo_h_rd are high for exactly this cycle.
  - fifo_h_data is pushed into the buffer at the end of the cycle; remaining is decremented.
  - Next state: READ1 in two-byte mode, otherwise GAP.
- READ1: same as READ0 for the second byte of the pair; then GAP.
- GAP:
  - One idle cycle with no select, so the FIFO flags settle before they are sampled again.
  - Go to DONE if remaining == 0 or an abort is pending; otherwise go to WAIT.
- DONE: pulse done for one cycle; go to IDLE.
- Abort rules:
  - An abort seen during READ0, READ1 or GAP is held pending and honoured at GAP, so a pair is never split.
  - Abort does not flush the buffer; already-read bytes still drain through the stream.
- Output buffer:
  - Circular, BUF_DEPTH entries.
  - A push and a pop in the same cycle are both performed.
  - Pushes are never dropped, because the free-space check is made in WAIT.
- Mode or count changes while busy are ignored.

## Timing
- Reset values: state IDLE, buffer empty; fifo_h_select, fifo_h_rd, out_valid, busy, done and err are all 0; remaining = 0; out_data = 0.
- Reset in mid-transfer returns to IDLE on the next edge and discards buffered data. The strobe drops the same cycle the reset state takes effect.
- start sampled high at edge N: busy = 1 from cycle N+1.
- Latency: fifo_h_data_available high in WAIT cycle M gives the strobe in cycle M+1 and out_valid in cycle M+2. This assumes the buffer was empty and the byte is not consumed earlier.
- Burst cycle count: 2 cycles per one-byte burst (READ0 + GAP); 3 cycles per two-byte burst (READ0 + READ1 + GAP). WAIT adds at least one cycle per burst.
- If out_ready is held low, the engine stalls in WAIT once free space is less than the burst size. No strobe is issued while stalled.
- The last byte's read is followed by GAP then DONE, so done pulses 2 cycles after the final strobe cycle.

## Test plan
- One-byte mode, count 3, data-available held high, out_ready = 1:
  - exactly 3 single-cycle strobes, each separated by GAP plus WAIT;
  - out_data sequence equals the FIFO bytes (e.g. 0x11, 0x22, 0x33);
  - done pulses once; remaining steps 3 → 0.
- Two-byte mode, count 4:
  - strobes occur in back-to-back pairs (READ0, READ1);
  - bytes 0xA1, 0xA2, 0xA3, 0xA4 come out in order.
- Two-byte mode, count 5: err pulses, busy stays 0, no strobe. Count 0 in either mode: done pulses, no strobe.
- Backpressure: BUF_DEPTH 4, two-byte mode, count 8, out_ready = 0:
  - exactly 4 bytes are read, then the engine stalls in WAIT;
  - raising out_ready resumes reading; all 8 bytes are delivered, none lost or duplicated.
- Abort asserted during READ0 in two-byte mode: READ1 still strobes, then DONE; the buffered pair remains deliverable. Abort asserted in WAIT: done pulses 1 cycle later.
- h_rst asserted mid-transfer while the buffer holds 2 bytes: the next cycle shows IDLE, out_valid = 0, remaining = 0, strobe low.
